// File: rtl/ucsbece154b_issue_sched.sv
`default_nettype none
// ============================================================================
// ucsbece154b_issue_sched : dual-issue scheduler, splits hazardous decode pairs
// Revision 1.0
// ============================================================================
module ucsbece154b_issue_sched #(
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instrD_i,
    input  logic [31:0]          instrD2_i,
    input  logic                 validD_i,
    input  logic                 validD2_i,
    input  logic                 ex_ready_i,
    input  logic                 flush_i,
    output logic [31:0]          issue0_instr_o,
    output logic                 issue0_valid_o,
    output logic [31:0]          issue1_instr_o,
    output logic                 issue1_valid_o,
    output logic                 stallD_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o,
    output logic [CNT_WIDTH-1:0] instr_cnt_o,
    output logic [CNT_WIDTH-1:0] split_cnt_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [0:0] {
        PAIR  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state;

    logic [31:0]          lane0_instr, lane1_instr;
    logic                 lane0_valid, lane1_valid;
    logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt, split_cnt;

    logic [6:0] op0, op1;
    logic [4:0] rd0, rd1, rs1_1, rs2_1;
    logic       writes0, writes1, reads_rs1_1, reads_rs2_1;
    logic       raw, waw, mem, ctl, conflict;

    always_comb begin
        op0   = instrD_i[6:0];
        rd0   = instrD_i[11:7];
        op1   = instrD2_i[6:0];
        rd1   = instrD2_i[11:7];
        rs1_1 = instrD2_i[19:15];
        rs2_1 = instrD2_i[24:20];

        writes0     = (op0 != OP_STORE) && (op0 != OP_BRANCH);
        writes1     = (op1 != OP_STORE) && (op1 != OP_BRANCH);
        reads_rs1_1 = (op1 != OP_LUI) && (op1 != OP_AUIPC) && (op1 != OP_JAL);
        reads_rs2_1 = (op1 == OP_OP) || (op1 == OP_STORE) || (op1 == OP_BRANCH);

        raw = writes0 && (rd0 != 5'd0) &&
              ((reads_rs1_1 && (rs1_1 == rd0)) || (reads_rs2_1 && (rs2_1 == rd0)));
        waw = writes0 && writes1 && (rd0 != 5'd0) && (rd0 == rd1);
        mem = ((op0 == OP_LOAD) || (op0 == OP_STORE)) &&
              ((op1 == OP_LOAD) || (op1 == OP_STORE));
        ctl = (op0 == OP_BRANCH) || (op0 == OP_JAL) || (op0 == OP_JALR);

        conflict = validD_i && validD2_i && (raw || waw || mem || ctl);
    end

    logic [31:0] nxt_instr0, nxt_instr1;
    logic        nxt_valid0, nxt_valid1, do_split;
    state_t      nxt_state;
    logic [1:0]  issue_cnt;

    always_comb begin
        nxt_valid0 = 1'b0;
        nxt_valid1 = 1'b0;
        do_split   = 1'b0;
        nxt_state  = PAIR;
        if (state == SPLIT) begin
            // Decode is still holding the pair; finish it with the younger slot.
            nxt_valid1 = validD2_i;
        end else if (conflict) begin
            nxt_valid0 = 1'b1;
            do_split   = 1'b1;
            nxt_state  = SPLIT;
        end else begin
            nxt_valid0 = validD_i;
            nxt_valid1 = validD2_i;
        end
        nxt_instr0 = nxt_valid0 ? instrD_i  : 32'd0;
        nxt_instr1 = nxt_valid1 ? instrD2_i : 32'd0;
        issue_cnt  = {1'b0, nxt_valid0 && (nxt_instr0 != NOP_INSTR)} +
                     {1'b0, nxt_valid1 && (nxt_instr1 != NOP_INSTR)};
    end

    always_comb begin
        stallD_o = 1'b0;
        if (reset && !flush_i) begin
            stallD_o = !ex_ready_i || ((state == PAIR) && conflict);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= PAIR;
            lane0_instr <= 32'd0;
            lane1_instr <= 32'd0;
            lane0_valid <= 1'b0;
            lane1_valid <= 1'b0;
            cycle_cnt   <= '0;
            instr_cnt   <= '0;
            split_cnt   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (flush_i) begin
                state       <= PAIR;
                lane0_instr <= 32'd0;
                lane1_instr <= 32'd0;
                lane0_valid <= 1'b0;
                lane1_valid <= 1'b0;
            end else if (ex_ready_i) begin
                state       <= nxt_state;
                lane0_instr <= nxt_instr0;
                lane1_instr <= nxt_instr1;
                lane0_valid <= nxt_valid0;
                lane1_valid <= nxt_valid1;
                instr_cnt   <= instr_cnt + CNT_WIDTH'(issue_cnt);
                if (do_split) begin
                    split_cnt <= split_cnt + 1'b1;
                end
            end
        end
    end

    assign issue0_instr_o = lane0_instr;
    assign issue0_valid_o = lane0_valid;
    assign issue1_instr_o = lane1_instr;
    assign issue1_valid_o = lane1_valid;
    assign cycle_cnt_o    = cycle_cnt;
    assign instr_cnt_o    = instr_cnt;
    assign split_cnt_o    = split_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_issue_sched.sv
`default_nettype none
// Directed bench for ucsbece154b_issue_sched (8-bit counters so wrap is reachable).
module tb_ucsbece154b_issue_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  instrD, instrD2;
    logic         validD, validD2, ex_ready, flush;
    logic [31:0]  i0, i1;
    logic         v0, v1, stall;
    logic [W-1:0] cyc, icnt, scnt;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] ncyc = '0;
    logic [W-1:0] exp_instr = '0;
    logic [W-1:0] exp_split = '0;

    ucsbece154b_issue_sched #(.CNT_WIDTH(W), .NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .reset(reset),
        .instrD_i(instrD), .instrD2_i(instrD2),
        .validD_i(validD), .validD2_i(validD2),
        .ex_ready_i(ex_ready), .flush_i(flush),
        .issue0_instr_o(i0), .issue0_valid_o(v0),
        .issue1_instr_o(i1), .issue1_valid_o(v1),
        .stallD_o(stall),
        .cycle_cnt_o(cyc), .instr_cnt_o(icnt), .split_cnt_o(scnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic va, input logic vb, input logic rdy, input logic fl);
        instrD = a; instrD2 = b; validD = va; validD2 = vb; ex_ready = rdy; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) ncyc = '0;
        else        ncyc = ncyc + 1'b1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(32'h13, 32'h13, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        reset = 1'b1;
        exp_instr = '0;
        exp_split = '0;
    endtask

    task automatic test_reset();
        n_cmp++; if ({v0, v1} !== 2'b00) begin n_bad++; $display("FAIL reset_valids: got %b expected 00", {v0, v1}); end
        n_cmp++; if ({i0, i1} !== 64'd0) begin n_bad++; $display("FAIL reset_instrs: got %h expected 0", {i0, i1}); end
        n_cmp++; if ({cyc, icnt, scnt} !== 24'd0) begin n_bad++; $display("FAIL reset_counters: got %h expected 0", {cyc, icnt, scnt}); end
        // stall must stay low while reset is held, even with a hazardous pair
        reset = 1'b0;
        drive(32'h00100293, 32'h00228313, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
        tick();
        reset = 1'b1;
        drive(32'h13, 32'h13, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_independent();
        drive(32'h00100293, 32'h00300393, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL indep_stall: got %b expected 0", stall); end
        tick();
        exp_instr = exp_instr + 8'd2;
        drive(32'h13, 32'h13, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if ({v0, i0, v1, i1} !== {1'b1, 32'h00100293, 1'b1, 32'h00300393}) begin n_bad++; $display("FAIL indep_lanes: got %b %h %b %h expected 1 00100293 1 00300393", v0, i0, v1, i1); end
        n_cmp++; if (icnt !== exp_instr) begin n_bad++; $display("FAIL indep_instr_cnt: got %0d expected %0d", icnt, exp_instr); end
        n_cmp++; if (scnt !== 8'd0) begin n_bad++; $display("FAIL indep_split_cnt: got %0d expected 0", scnt); end
    endtask

    task automatic test_split_pair(input logic [31:0] a, input logic [31:0] b);
        drive(a, b, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL split_stall1 %h/%h: got %b expected 1", a, b, stall); end
        tick();
        n_cmp++; if ({v0, i0, v1} !== {1'b1, a, 1'b0}) begin n_bad++; $display("FAIL split_cycle1 %h/%h: got %b %h %b expected 1 %h 0", a, b, v0, i0, v1, a); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL split_stall2 %h/%h: got %b expected 0", a, b, stall); end
        tick();
        exp_instr = exp_instr + 8'd2;
        exp_split = exp_split + 8'd1;
        drive(32'h13, 32'h13, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if ({v0, v1, i1} !== {1'b0, 1'b1, b}) begin n_bad++; $display("FAIL split_cycle2 %h/%h: got %b %b %h expected 0 1 %h", a, b, v0, v1, i1, b); end
        n_cmp++; if ({icnt, scnt} !== {exp_instr, exp_split}) begin n_bad++; $display("FAIL split_counts %h/%h: got %0d/%0d expected %0d/%0d", a, b, icnt, scnt, exp_instr, exp_split); end
    endtask

    task automatic test_raw();
        test_split_pair(32'h00100293, 32'h00228313);
    endtask

    task automatic test_mem_branch();
        test_split_pair(32'h00002403, 32'h00502223);
        test_split_pair(32'h00000463, 32'h00300393);
    endtask

    task automatic test_single();
        // hazardous encodings, but only one slot valid: never split
        drive(32'h00100293, 32'h00228313, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL single1_stall: got %b expected 0", stall); end
        tick();
        n_cmp++; if ({v0, v1, i1} !== {1'b0, 1'b1, 32'h00228313}) begin n_bad++; $display("FAIL single1_lanes: got %b %b %h expected 0 1 00228313", v0, v1, i1); end
        drive(32'h00100293, 32'h00228313, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        n_cmp++; if ({v0, i0, v1} !== {1'b1, 32'h00100293, 1'b0}) begin n_bad++; $display("FAIL single0_lanes: got %b %h %b expected 1 00100293 0", v0, i0, v1); end
        drive(32'h00100293, 32'h00228313, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        exp_instr = exp_instr + 8'd2;
        n_cmp++; if ({v0, v1} !== 2'b00) begin n_bad++; $display("FAIL bubble_lanes: got %b expected 00", {v0, v1}); end
        n_cmp++; if ({icnt, scnt} !== {exp_instr, exp_split}) begin n_bad++; $display("FAIL single_counts: got %0d/%0d expected %0d/%0d", icnt, scnt, exp_instr, exp_split); end
    endtask

    task automatic test_nop();
        drive(32'h00000013, 32'h00000013, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        n_cmp++; if ({v0, i0, v1, i1} !== {1'b1, 32'h13, 1'b1, 32'h13}) begin n_bad++; $display("FAIL nop_lanes: got %b %h %b %h expected 1 00000013 1 00000013", v0, i0, v1, i1); end
        n_cmp++; if (icnt !== exp_instr) begin n_bad++; $display("FAIL nop_instr_cnt: got %0d expected %0d", icnt, exp_instr); end
        n_cmp++; if (cyc !== ncyc) begin n_bad++; $display("FAIL nop_cycle_cnt: got %0d expected %0d", cyc, ncyc); end
    endtask

    task automatic test_stall_flush();
        drive(32'h00100293, 32'h00228313, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_signal: got %b expected 1", stall); end
        tick(); tick(); tick();
        n_cmp++; if ({v0, i0, v1, i1} !== {1'b1, 32'h13, 1'b1, 32'h13}) begin n_bad++; $display("FAIL stall_frozen: got %b %h %b %h expected 1 00000013 1 00000013", v0, i0, v1, i1); end
        n_cmp++; if ({icnt, scnt, cyc} !== {exp_instr, exp_split, ncyc}) begin n_bad++; $display("FAIL stall_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", icnt, scnt, cyc, exp_instr, exp_split, ncyc); end
        drive(32'h00100293, 32'h00228313, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        exp_instr = exp_instr + 8'd1;
        exp_split = exp_split + 8'd1;
        n_cmp++; if ({v0, i0, v1} !== {1'b1, 32'h00100293, 1'b0}) begin n_bad++; $display("FAIL stall_release: got %b %h %b expected 1 00100293 0", v0, i0, v1); end
        drive(32'h00100293, 32'h00228313, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b expected 0", stall); end
        tick();
        drive(32'h00100293, 32'h00228313, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if ({v0, v1} !== 2'b00) begin n_bad++; $display("FAIL flush_valids: got %b expected 00", {v0, v1}); end
        n_cmp++; if ({icnt, scnt} !== {exp_instr, exp_split}) begin n_bad++; $display("FAIL flush_counts: got %0d/%0d expected %0d/%0d", icnt, scnt, exp_instr, exp_split); end
        // back in PAIR: the same hazardous pair must request a stall again
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_state_pair: got stall %b expected 1", stall); end
    endtask

    task automatic test_reset_split();
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rsplit_in_split: got stall %b expected 0", stall); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_cmp++; if ({v0, v1, i0, i1, cyc, icnt, scnt} !== 90'd0) begin n_bad++; $display("FAIL rsplit_zero: got %b %b %h %h %0d %0d %0d expected all 0", v0, v1, i0, i1, cyc, icnt, scnt); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rsplit_state_pair: got stall %b expected 1", stall); end
        drive(32'h13, 32'h13, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 255; k++) tick();
        n_cmp++; if (cyc !== 8'hFF) begin n_bad++; $display("FAIL wrap_allones: got %h expected ff", cyc); end
        tick();
        n_cmp++; if (cyc !== 8'h00) begin n_bad++; $display("FAIL wrap_zero: got %h expected 00", cyc); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_independent();
        test_raw();
        test_mem_branch();
        test_single();
        test_nop();
        test_stall_flush();
        test_reset_split();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
